// File: rtl/ram_responder.sv
// ram_responder: word RAM slave with LAT busy cycles and FREE/BUSY/ACCESS/ERROR status.
// Define RAM_RESPONDER_ERROR_EN to flag misaligned, out-of-range and read+write requests.
module ram_responder #(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          r_ren;
  logic          r_wen;
  logic [31:0]   r_addr;
  logic [31:0]   r_data;
  logic [31:0]   r_load;
  logic [31:0]   r_mem [DEPTH];

  logic          w_req;
  logic          w_bad;
  logic          w_mismatch;
  logic          w_accept;
  logic          w_enter_acc;
  logic          w_src_wr;
  logic          w_src_rd;
  logic [AW-1:0] w_src_idx;
  logic [31:0]   w_src_data;

  assign w_req      = ramREN | ramWEN;
  assign w_mismatch = (ramREN != r_ren) | (ramWEN != r_wen) |
                      (ramaddr != r_addr);

`ifdef RAM_RESPONDER_ERROR_EN
  assign w_bad = (ramaddr[1:0] != 2'b00) |
                 ({2'b00, ramaddr[31:2]} >= 32'(DEPTH)) |
                 (ramREN & ramWEN);
`else
  assign w_bad = 1'b0;
`endif

  // With LAT=0 the access happens on the accepting edge, so use live inputs.
  always_comb begin
    w_src_wr   = r_wen;
    w_src_rd   = r_ren & ~r_wen;
    w_src_idx  = r_addr[AW+1:2];
    w_src_data = r_data;
    if (r_state == IDLE) begin
      w_src_wr   = ramWEN;
      w_src_rd   = ramREN & ~ramWEN;
      w_src_idx  = ramaddr[AW+1:2];
      w_src_data = ramstore;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_enter_acc = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req && w_bad) begin
          w_next = ERR;
        end else if (w_req) begin
          w_accept = 1'b1;
          if (LAT == 0) begin
            w_next      = ACC;
            w_enter_acc = 1'b1;
          end else begin
            w_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (w_mismatch) begin
          w_next = IDLE;
        end else if (r_cnt == 4'd1) begin
          w_next      = ACC;
          w_enter_acc = 1'b1;
        end
      end
      ACC: w_next = IDLE;
      ERR: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt  <= 4'd0;
      r_ren  <= 1'b0;
      r_wen  <= 1'b0;
      r_addr <= 32'd0;
      r_data <= 32'd0;
      r_load <= 32'd0;
    end else begin
      r_load <= 32'd0;
      if (w_accept) begin
        r_ren  <= ramREN;
        r_wen  <= ramWEN;
        r_addr <= ramaddr;
        r_data <= ramstore;
        r_cnt  <= 4'(LAT);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_acc && w_src_rd) begin
        r_load <= r_mem[w_src_idx];
      end
    end
  end

  // Storage is never cleared; reset only blocks a pending commit.
  always_ff @(posedge CLK) begin
    if (!RST && w_enter_acc && w_src_wr) begin
      r_mem[w_src_idx] <= w_src_data;
    end
  end

  assign ramload  = r_load;
  assign ramstate = r_state;

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: three instances (LAT 2, 3, 0) on one input bus,
// checked each cycle against a transaction-level reference model.
module tb_ram_responder;

  localparam int DEPTH = 1024;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] data = 32'd0;
  logic [31:0] ld [3];
  logic [1:0]  st [3];

  ram_responder #(.LAT(2), .DEPTH(DEPTH)) u_lat2 (
    .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen),
    .ramaddr(addr), .ramstore(data),
    .ramload(ld[0]), .ramstate(st[0])
  );

  ram_responder #(.LAT(3), .DEPTH(DEPTH)) u_lat3 (
    .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen),
    .ramaddr(addr), .ramstore(data),
    .ramload(ld[1]), .ramstate(st[1])
  );

  ram_responder #(.LAT(0), .DEPTH(DEPTH)) u_lat0 (
    .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen),
    .ramaddr(addr), .ramstore(data),
    .ramload(ld[2]), .ramstate(st[2])
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          lat_of [3] = '{2, 3, 0};
  int          mst    [3];
  int          mbusy  [3];
  bit          mren   [3];
  bit          mwen   [3];
  logic [31:0] maddr  [3];
  logic [31:0] mdata  [3];
  logic [31:0] mload  [3];
  bit          mknown [3];
  logic [31:0] mmem [int];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(bit rn, bit wn, logic [31:0] a);
`ifdef RAM_RESPONDER_ERROR_EN
    return (a % 4 != 0) || ((a / 4) >= 32'(DEPTH)) || (rn && wn);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_access(int k);
    int key;
    key = k * DEPTH + int'((maddr[k] / 4) % 32'(DEPTH));
    if (mwen[k]) begin
      mmem[key] = mdata[k];
    end else if (mmem.exists(key)) begin
      mload[k] = mmem[key];
    end else begin
      mknown[k] = 1'b0;
    end
  endtask

  // States: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR; mbusy = BUSY cycles left.
  task automatic model_edge(bit r, bit rn, bit wn, logic [31:0] a,
                            logic [31:0] d);
    for (int k = 0; k < 3; k++) begin
      mload[k]  = 32'd0;
      mknown[k] = 1'b1;
      if (r) begin
        mst[k] = 0;
      end else if (mst[k] == 0) begin
        if (rn || wn) begin
          if (is_bad(rn, wn, a)) begin
            mst[k] = 3;
          end else begin
            mren[k] = rn; mwen[k] = wn; maddr[k] = a; mdata[k] = d;
            if (lat_of[k] == 0) begin
              do_access(k);
              mst[k] = 2;
            end else begin
              mbusy[k] = lat_of[k];
              mst[k]   = 1;
            end
          end
        end
      end else if (mst[k] == 1) begin
        if (rn != mren[k] || wn != mwen[k] || a != maddr[k]) begin
          mst[k] = 0;
        end else if (mbusy[k] == 1) begin
          do_access(k);
          mst[k] = 2;
        end else begin
          mbusy[k]--;
        end
      end else begin
        mst[k] = 0;
      end
    end
  endtask

  task automatic step(bit r, bit rn, bit wn, logic [31:0] a,
                      logic [31:0] d);
    RST = r; ren = rn; wen = wn; addr = a; data = d;
    @(posedge CLK);
    model_edge(r, rn, wn, a, d);
    cyc++;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("state_lat%0d_c%0d", lat_of[k], cyc),
          32'(st[k]), 32'(mst[k]));
      if (mknown[k])
        chk($sformatf("load_lat%0d_c%0d", lat_of[k], cyc),
            ld[k], mload[k]);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    bit          rn, wn;
    logic [31:0] a, d;
    int          op, hold, gap;

    for (int k = 0; k < 3; k++) begin
      mst[k] = 0; mbusy[k] = 0; mren[k] = 0; mwen[k] = 0;
      maddr[k] = 0; mdata[k] = 0; mload[k] = 0; mknown[k] = 1;
    end

    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_state_%0d", k), 32'(st[k]), 32'd0);
      chk($sformatf("reset_load_%0d", k), ld[k], 32'd0);
    end
    idle(1);

    // LAT=2 write then read of 0x40
    step(1'b0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    chk("wr40_n1_busy", 32'(st[0]), 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    chk("wr40_n2_busy", 32'(st[0]), 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    chk("wr40_n3_access", 32'(st[0]), 32'd2);
    idle(1);
    chk("wr40_n4_free", 32'(st[0]), 32'd0);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
    chk("rd40_access", 32'(st[0]), 32'd2);
    chk("rd40_data", ld[0], 32'hDEAD_BEEF);
    idle(2);

    // LAT=2 read 0x80 dropped after one cycle
    step(1'b0, 1'b1, 1'b0, 32'h80, 32'd0);
    chk("rd80_busy", 32'(st[0]), 32'd1);
    idle(1);
    chk("rd80_abort_free", 32'(st[0]), 32'd0);
    idle(3);

    // LAT=0 back-to-back reads
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 32'h0, 32'h1111_1111);
    idle(2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 32'h4, 32'h2222_2222);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'd0);
    chk("lat0_rd0_access", 32'(st[2]), 32'd2);
    chk("lat0_rd0_data", ld[2], 32'h1111_1111);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'd0);
    chk("lat0_rd0_free", 32'(st[2]), 32'd0);
    chk("lat0_rd0_load0", ld[2], 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h4, 32'd0);
    chk("lat0_rd4_access", 32'(st[2]), 32'd2);
    chk("lat0_rd4_data", ld[2], 32'h2222_2222);
    step(1'b0, 1'b1, 1'b0, 32'h4, 32'd0);
    chk("lat0_rd4_free", 32'(st[2]), 32'd0);
    idle(4);

`ifdef RAM_RESPONDER_ERROR_EN
    step(1'b0, 1'b1, 1'b0, 32'h42, 32'd0);
    for (int k = 0; k < 3; k++)
      chk($sformatf("misalign_err_%0d", k), 32'(st[k]), 32'd3);
    idle(1);
    chk("misalign_free", 32'(st[0]), 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h1000, 32'h5555_5555);
    chk("oob_err", 32'(st[1]), 32'd3);
    idle(1);
    chk("oob_free", 32'(st[1]), 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h40, 32'h6666_6666);
    chk("rdwr_err", 32'(st[2]), 32'd3);
    idle(1);
    chk("rdwr_free", 32'(st[2]), 32'd0);
`else
    step(1'b0, 1'b1, 1'b0, 32'h42, 32'd0);
    chk("misalign_access", 32'(st[2]), 32'd2);
    chk("misalign_data", ld[2], 32'hDEAD_BEEF);
    idle(1);
    step(1'b0, 1'b1, 1'b1, 32'h8, 32'h3333_3333);
    chk("rdwr_write_access", 32'(st[2]), 32'd2);
    chk("rdwr_write_load0", ld[2], 32'd0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 32'h8, 32'd0);
    chk("rdwr_readback", ld[2], 32'h3333_3333);
`endif
    idle(3);

    // LAT=3 write cancelled by reset
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 32'h10, 32'hA5A5_A5A5);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 32'h10, 32'h1234_5678);
    step(1'b0, 1'b0, 1'b1, 32'h10, 32'h1234_5678);
    step(1'b1, 1'b0, 1'b1, 32'h10, 32'h1234_5678);
    chk("rst_cancel_free", 32'(st[1]), 32'd0);
    idle(1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
    chk("rst_cancel_access", 32'(st[1]), 32'd2);
    chk("rst_cancel_data", ld[1], 32'hA5A5_A5A5);
    idle(2);

    for (int t = 0; t < 250; t++) begin
      op   = $urandom_range(0, 9);
      rn   = (op <= 3) || (op == 8);
      wn   = (op >= 4) && (op <= 8);
      a    = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'(DEPTH) << 2);
      d    = $urandom;
      hold = $urandom_range(1, 6);
      gap  = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++)
        step($urandom_range(0, 79) == 0, rn, wn, a, d);
      idle(gap);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter: LAT, default 2, BUSY cycles before ACCESS; legal range 0..15.
REQ-002 Parameter: DEPTH, default 1024, number of 32-bit words stored; power of two.
REQ-003 Port: CLK  input  1  single clock, all state changes on rising edge.
REQ-004 Port: RST  input  1  reset, synchronous, active-high.
REQ-005 Port: ramREN  input  1  read request from the cache/arbiter side.
REQ-006 Port: ramWEN  input  1  write request from the cache/arbiter side.
REQ-007 Port: ramaddr  input  32  byte address; word index is ramaddr[31:2], byte offset is ramaddr[1:0].
REQ-008 Port: ramstore  input  32  write data.
REQ-009 Port: ramload  output  32  read data; valid only while ramstate is ACCESS.
REQ-010 Port: ramstate  output  2  registered response status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-011 The block SHALL implement FSM states IDLE, WAIT, ACC, ERR, mapping to ramstate FREE, BUSY, ACCESS, ERROR respectively.
REQ-012 In IDLE, a request is any cycle with ramREN or ramWEN high; the block SHALL latch ramaddr, ramREN, ramWEN and ramstore at that edge.
REQ-013 For a valid request seen in IDLE in cycle N, the block SHALL report BUSY in cycles N+1..N+LAT and ACCESS in cycle N+LAT+1; with LAT=0, ACCESS is reported in N+1.
REQ-014 A write SHALL commit to the storage array at the edge entering ACC, exactly once per transaction.
REQ-015 A read SHALL drive the addressed word on ramload during ACC; ramload SHALL be 0 in every other state.
REQ-016 In WAIT, if the live ramREN, ramWEN or ramaddr differ from latched values, the block SHALL abort to IDLE next cycle with no write.
REQ-017 After ACC and after ERR, the block SHALL return to IDLE for at least one cycle (FREE) before accepting a new request; a request still held then starts a new transaction.
REQ-018 The latency counter SHALL be 4 bits, loaded with LAT on acceptance, decremented in WAIT; WAIT exits to ACC when the count reaches 1 (or directly from IDLE when LAT=0).
REQ-019 Storage contents SHALL power up and remain undefined until written; reset SHALL NOT clear storage.

Reset
REQ-020 With RST high at an edge, the block SHALL enter IDLE, ramstate FREE, ramload 0, counter 0; RST has priority over all other inputs.
REQ-021 RST asserted during WAIT SHALL cancel the transaction; no write commits.

Configuration
REQ-022 Macro RAM_RESPONDER_ERROR_EN, when defined: a request with ramaddr[1:0]!=0, word index >= DEPTH, or ramREN and ramWEN both high SHALL go IDLE->ERR (ERROR one cycle in N+1), then IDLE, with no storage access.
REQ-023 When RAM_RESPONDER_ERROR_EN is undefined: ERROR is never reported, byte offset is ignored, word index wraps modulo DEPTH, and ramWEN has priority over ramREN.

Verification
REQ-024 LAT=2: write 0xDEADBEEF to 0x40 in cycle N -> ramstate BUSY N+1,N+2, ACCESS N+3, FREE N+4; then read 0x40 -> ACCESS with ramload=0xDEADBEEF.
REQ-025 LAT=2: read 0x80 in cycle N, drop ramREN in N+1 -> FREE in N+2, ACCESS never reported.
REQ-026 Macro defined: read 0x42 -> ERROR in N+1, FREE in N+2; macro undefined: same read returns word at 0x40 in ACCESS.
REQ-027 LAT=3: write 0x12345678 to 0x10, RST pulsed in N+2 -> FREE in N+3; later read 0x10 returns the prior contents, not 0x12345678.
REQ-028 LAT=0: reads held continuously on 0x0 then 0x4 -> ramstate ACCESS, FREE, ACCESS alternating with correct ramload each ACCESS.
REQ-029 Macro defined, DEPTH=1024: write to 0x1000 (index 1024) -> ERROR one cycle; ramREN and ramWEN both high -> ERROR one cycle.
